// File: rtl/enc_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder.
package enc_pkg;
    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, SCAN} enc_state_t;
endpackage

// File: rtl/enc8_scan_prio_enc8.sv
// Lowest-set-bit priority encoder; idx is 0 for an all-zero vector.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         onehot_or_zero
);

    always_comb begin
        idx = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign onehot_or_zero = ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/enc8_scan.sv
// Accepts a request vector and emits the index of each set bit, lowest first, one per handshake.
module enc8_scan
    import enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         out_last,
    output logic         zero
);

    enc_state_t     state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   low_idx;
    logic           low_single;
    logic [N-1:0]   clr_mask;

    prio_enc8 u_prio (
        .vec            (pending_q),
        .idx            (low_idx),
        .onehot_or_zero (low_single)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign out_code  = low_idx;
    // pending is never zero in SCAN, so single-or-zero means exactly one bit here.
    assign out_last  = (state_q == SCAN) && low_single;
    assign zero      = zero_q;

    always_comb begin
        clr_mask          = '0;
        clr_mask[low_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        pending_d = in_vec;
                        state_d   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (out_last) begin
                        pending_d = '0;
                        state_d   = IDLE;
                    end else begin
                        pending_d = pending_q & ~clr_mask;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_enc8_scan.sv
// Directed bench for enc8_scan: outputs sampled on the falling edge, inputs driven there too.
module tb_enc8_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    enc8_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] code, input logic last);
        chk({tag, "_valid"}, 8'(out_valid), 8'd1);
        chk({tag, "_code"},  8'(out_code),  8'(code));
        chk({tag, "_last"},  8'(out_last),  8'(last));
        chk({tag, "_ready"}, 8'(in_ready),  8'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 8'(out_valid), 8'd0);
        chk({tag, "_ready"}, 8'(in_ready),  8'd1);
    endtask

    // Presents a vector for one cycle; returns on the falling edge after the accept edge.
    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int beats;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst_code", 8'(out_code), 8'd0);
        chk("rst_last", 8'(out_last), 8'd0);
        chk("rst_zero", 8'(zero), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of scanning 0xFF
        send(8'hFF);
        chk_beat("ff_pre_rst", 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 8'(out_valid), 8'd0);
        chk("midrst_code",  8'(out_code),  8'd0);
        chk("midrst_last",  8'(out_last),  8'd0);
        chk("midrst_ready", 8'(in_ready),  8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");
        out_ready = 1'b1;
        send(8'h01);
        chk_beat("v01", 3'd0, 1'b1);
        @(negedge clk);
        chk_idle("v01_done");

        // Single one-hot
        send(8'b0010_0000);
        chk_beat("v20", 3'd5, 1'b1);
        @(negedge clk);
        chk_idle("v20_done");

        // Three bits, back-to-back beats
        send(8'b1000_0101);
        chk_beat("v85_b0", 3'd0, 1'b0);
        @(negedge clk);
        chk_beat("v85_b1", 3'd2, 1'b0);
        @(negedge clk);
        chk_beat("v85_b2", 3'd7, 1'b1);
        @(negedge clk);
        chk_idle("v85_done");

        // Backpressure holds the code stable
        out_ready = 1'b0;
        send(8'b0000_0110);
        for (int i = 0; i < 3; i++) begin
            chk_beat("bp_hold", 3'd1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk_beat("bp_b0", 3'd1, 1'b0);
        @(negedge clk);
        chk_beat("bp_b1", 3'd2, 1'b1);
        @(negedge clk);
        chk_idle("bp_done");

        // All-zero vector: single zero pulse, no beats
        chk("zero_before", 8'(zero), 8'd0);
        send(8'h00);
        chk("zero_pulse", 8'(zero), 8'd1);
        chk_idle("zero_c0");
        @(negedge clk);
        chk("zero_after", 8'(zero), 8'd0);
        chk_idle("zero_c1");

        // Full vector, out_ready toggling, in_valid held high throughout
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        @(negedge clk);
        in_vec = 8'h01;
        cyc    = 0;
        beats  = 0;
        while (out_valid && cyc < 40) begin
            chk_beat("ff_scan", 3'(cyc >> 1), (cyc >> 1) == 7);
            chk("ff_nozero", 8'(zero), 8'd0);
            out_ready = cyc[0];
            if (out_ready) beats++;
            cyc++;
            @(negedge clk);
        end
        chk("ff_scan_cycles", 8'(cyc), 8'd16);
        chk("ff_beats", 8'(beats), 8'd8);
        // The held in_valid is accepted only now, carrying 0x01
        chk_idle("ff_idle");
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat("held_v01", 3'd0, 1'b1);
        @(negedge clk);
        chk_idle("held_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/enc8_scan.md
# enc8_scan

Sequential 8-to-3 encoder: the counterpart of the team's 3-to-8 one-hot decoder. It accepts an 8-bit request/one-hot vector through a valid/ready handshake. It then emits the 3-bit index of every set bit, one per output handshake, in ascending bit order. It sits between decoded select/request lines and any consumer that needs binary indices, for example an arbiter queue or a register-file address port.

## Interface
Parameters:
- N, 8, input vector width; fixed at 8 for this block.
- W, 3, code width; localparam, $clog2(N).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer presents in_vec.
- in_ready  out  1  block can accept a vector.
- in_vec  in  8  request vector; bit i set means index i is requested.
- out_valid  out  1  out_code is valid.
- out_ready  in  1  consumer accepts out_code.
- out_code  out  3  index of the lowest pending set bit.
- out_last  out  1  out_code is the final index of the current vector.
- zero  out  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- States: IDLE and SCAN. Internal register pending[7:0].
- IDLE behaviour:
  - in_ready=1, out_valid=0.
  - Accept happens when in_valid && in_ready.
  - Accept with in_vec==0: zero=1 on the next cycle; state stays IDLE; pending is unchanged.
  - Accept with in_vec!=0: pending<=in_vec; state goes to SCAN.
- SCAN behaviour:
  - in_ready=0, out_valid=1.
  - out_code = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
- Output handshake (out_valid && out_ready): clear pending[out_code]. If out_last=1, clear pending and go to IDLE.
- While out_valid && !out_ready: out_code and out_last hold stable, because pending is unchanged.
- Indices come out strictly in ascending order. Each set bit is emitted exactly once, so the number of beats equals popcount(in_vec), from 1 to 8.
- No overlap: a new vector is accepted no earlier than the cycle after the last output handshake.
- Reset values, asynchronous on rst_n=0:
  - Registers: state=IDLE, pending=0, zero=0.
  - Outputs while in reset: out_valid=0, out_code=0, out_last=0, in_ready=1.
- Reset mid-operation: remaining indices are discarded, and out_valid drops immediately. After rst_n rises, the next vector is handled normally.
- zero is registered and never coincides with out_valid=1.

## Timing
- Latency from accept to the first out_valid=1 is 1 cycle.
- A vector with k set bits takes k cycles with out_ready held high, plus 1 IDLE cycle before the next accept. Total occupancy is k+1 cycles per vector.
- out_code and out_last are combinational from the registered pending and state, with no combinational path from in_vec.
- in_ready depends only on state, not on in_valid.
- out_valid depends only on state, not on out_ready.
- The zero pulse is asserted the cycle after accept, for exactly 1 cycle.

## Structure
- Shared package enc_pkg:
  - localparams N=8 and W=3.
  - typedef enum logic {IDLE, SCAN} enc_state_t.
- Sub-module prio_enc8: combinational lowest-set-bit encoder.
  - Inputs: vec[7:0].
  - Outputs: idx[2:0] and onehot_or_zero (popcount ≤ 1).
- prio_enc8 is instantiated once on pending.
- Top-level enc8_scan holds the state register, pending register, zero flag and handshake logic.

## Test plan
- Reset: assert rst_n=0 during SCAN of 8'hFF.
  - Required: out_valid=0, out_code=0, out_last=0, in_ready=1 immediately.
  - After release: 8'h01 yields a single beat, code 0, last=1.
- One-hot 8'b0010_0000 with out_ready=1: required single beat, code 5 with last=1, then in_ready=1 on the next cycle.
- Multi-bit 8'b1000_0101 with out_ready=1: required codes 0, 2, 7 on consecutive cycles, with last=1 only on 7.
- Backpressure 8'b0000_0110 with out_ready=0 for 3 cycles:
  - Required: code 1 is held stable, last=0, in_ready=0.
  - Then out_ready=1: codes 1, 2, with last on 2.
- Zero vector 8'h00: required zero=1 for exactly 1 cycle, out_valid stays 0, in_ready stays 1.
- Full vector 8'hFF with out_ready toggling every cycle:
  - Required: codes 0 to 7, each accepted once, in order.
  - Required: last=1 only on 7; total 16 cycles in SCAN.
  - Required: an in_valid held high is not accepted until IDLE.
